// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Brief    : ID-side ALU decode/issue with a 2-entry skid buffer into ID/EX.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int WIDTH  = 32,
    parameter int CODE_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [WIDTH-1:0]  rs_data,
    input  logic [WIDTH-1:0]  rt_data,
    input  logic [15:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  src_a,
    output logic [WIDTH-1:0]  src_b,
    output logic [CODE_W-1:0] sig_alu_control,
    output logic              illegal_op
);

    // ALU operation codes shared with the EX stage
    localparam logic [CODE_W-1:0] c_alu_and = CODE_W'(0);
    localparam logic [CODE_W-1:0] c_alu_or  = CODE_W'(1);
    localparam logic [CODE_W-1:0] c_alu_add = CODE_W'(2);
    localparam logic [CODE_W-1:0] c_alu_sub = CODE_W'(6);

    logic [CODE_W-1:0] w_code;
    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic              w_ill;
    logic [WIDTH-1:0]  w_sext;
    logic [WIDTH-1:0]  w_zext;

    assign w_sext = {{(WIDTH-16){imm[15]}}, imm};
    assign w_zext = {{(WIDTH-16){1'b0}}, imm};

    always_comb begin
        w_code = c_alu_add;
        w_a    = rs_data;
        w_b    = rt_data;
        w_ill  = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20, 6'h21: w_code = c_alu_add;
                    6'h22, 6'h23: w_code = c_alu_sub;
                    6'h24:        w_code = c_alu_and;
                    6'h25:        w_code = c_alu_or;
                    default:      w_ill  = 1'b1;
                endcase
            end
            6'h08, 6'h09, 6'h23, 6'h2B: begin
                w_code = c_alu_add;
                w_b    = w_sext;
            end
            6'h0C: begin
                w_code = c_alu_and;
                w_b    = w_zext;
            end
            6'h0D: begin
                w_code = c_alu_or;
                w_b    = w_zext;
            end
            6'h04: w_code = c_alu_sub;
            default: w_ill = 1'b1;
        endcase
        // Unsupported encodings become a harmless add of zeros
        if (w_ill) begin
            w_code = c_alu_add;
            w_a    = '0;
            w_b    = '0;
        end
    end

    logic              r_head_valid;
    logic [WIDTH-1:0]  r_head_a;
    logic [WIDTH-1:0]  r_head_b;
    logic [CODE_W-1:0] r_head_code;
    logic              r_head_ill;
    logic              r_skid_valid;
    logic [WIDTH-1:0]  r_skid_a;
    logic [WIDTH-1:0]  r_skid_b;
    logic [CODE_W-1:0] r_skid_code;
    logic              r_skid_ill;
    logic              r_in_ready;

    logic w_accept;
    logic w_head_free;

    assign w_accept    = in_valid & r_in_ready;
    assign w_head_free = ~r_head_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_valid <= 1'b0;
            r_head_a     <= '0;
            r_head_b     <= '0;
            r_head_code  <= c_alu_add;
            r_head_ill   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_a     <= '0;
            r_skid_b     <= '0;
            r_skid_code  <= c_alu_add;
            r_skid_ill   <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_head_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_head_free) begin
            // Head drains or is empty: refill from skid first, else from input
            r_head_valid <= r_skid_valid | w_accept;
            if (r_skid_valid) begin
                r_head_a    <= r_skid_a;
                r_head_b    <= r_skid_b;
                r_head_code <= r_skid_code;
                r_head_ill  <= r_skid_ill;
            end else if (w_accept) begin
                r_head_a    <= w_a;
                r_head_b    <= w_b;
                r_head_code <= w_code;
                r_head_ill  <= w_ill;
            end
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_a     <= w_a;
            r_skid_b     <= w_b;
            r_skid_code  <= w_code;
            r_skid_ill   <= w_ill;
            r_in_ready   <= 1'b0;
        end
    end

    assign in_ready        = r_in_ready;
    assign out_valid       = r_head_valid;
    assign src_a           = r_head_a;
    assign src_b           = r_head_b;
    assign sig_alu_control = r_head_code;
    assign illegal_op      = r_head_ill;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Brief    : Self-checking bench for alu_issue_stage against a FIFO/decode model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    localparam logic [4:0] ALU_AND = 5'd0;
    localparam logic [4:0] ALU_OR  = 5'd1;
    localparam logic [4:0] ALU_ADD = 5'd2;
    localparam logic [4:0] ALU_SUB = 5'd6;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  code;
        logic        ill;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic [15:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  sig_alu_control;
    logic        illegal_op;

    int n_tests = 0;
    int n_fail  = 0;
    ent_t q[$];

    alu_issue_stage #(.WIDTH(32), .CODE_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .src_a(src_a), .src_b(src_b), .sig_alu_control(sig_alu_control), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    function automatic ent_t ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [31:0] rs, input logic [31:0] rt,
                                        input logic [15:0] im);
        ent_t e;
        e.a = rs; e.b = rt; e.ill = 1'b0; e.code = ALU_ADD;
        if (op == 6'h00) begin
            if (fn == 6'h20 || fn == 6'h21)      e.code = ALU_ADD;
            else if (fn == 6'h22 || fn == 6'h23) e.code = ALU_SUB;
            else if (fn == 6'h24)                e.code = ALU_AND;
            else if (fn == 6'h25)                e.code = ALU_OR;
            else                                 e.ill  = 1'b1;
        end else if (op == 6'h08 || op == 6'h09 || op == 6'h23 || op == 6'h2B) begin
            e.b = 32'(signed'(im));
        end else if (op == 6'h0C) begin
            e.code = ALU_AND; e.b = {16'h0, im};
        end else if (op == 6'h0D) begin
            e.code = ALU_OR; e.b = {16'h0, im};
        end else if (op == 6'h04) begin
            e.code = ALU_SUB;
        end else begin
            e.ill = 1'b1;
        end
        if (e.ill) begin e.a = 0; e.b = 0; e.code = ALU_ADD; end
        return e;
    endfunction

    // Advance one clock, updating the capacity-2 FIFO model from model-predicted handshakes
    task automatic tick();
        bit acc, drn;
        ent_t e;
        acc = in_valid && (q.size() < 2);
        drn = (q.size() > 0) && out_ready;
        e = ref_decode(opcode, funct, rs_data, rt_data, imm);
        @(posedge clk);
        if (drn) void'(q.pop_front());
        if (flush) q.delete();
        else if (acc) q.push_back(e);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [15:0] im);
        in_valid = 1'b1; opcode = op; funct = fn; rs_data = rs; rt_data = rt; imm = im;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || src_a !== 0 || src_b !== 0 ||
            sig_alu_control !== ALU_ADD || illegal_op !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: ov=%b ir=%b a=%h b=%h code=%0d ill=%b", out_valid, in_ready,
                     src_a, src_b, sig_alu_control, illegal_op);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        out_ready = 1'b1;
        drive(6'h00, 6'h20, 32'd5, 32'd7, 16'h0);
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || sig_alu_control !== ALU_ADD || src_a !== 32'd5 ||
            src_b !== 32'd7 || illegal_op !== 1'b0) begin
            n_fail++;
            $display("FAIL add_rr: ov=%b code=%0d a=%h b=%h ill=%b want 1 %0d 5 7 0",
                     out_valid, sig_alu_control, src_a, src_b, illegal_op, ALU_ADD);
        end
        drive(6'h08, 6'h00, 32'd10, 32'd99, 16'hFFFF);
        tick();
        n_tests++;
        if (sig_alu_control !== ALU_ADD || src_a !== 32'd10 || src_b !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL addi_sext: code=%0d a=%h b=%h want %0d 0000000a ffffffff",
                     sig_alu_control, src_a, src_b, ALU_ADD);
        end
        drive(6'h0D, 6'h00, 32'd1, 32'd2, 16'h8001);
        tick();
        n_tests++;
        if (sig_alu_control !== ALU_OR || src_b !== 32'h00008001) begin
            n_fail++;
            $display("FAIL ori_zext: code=%0d b=%h want %0d 00008001", sig_alu_control, src_b, ALU_OR);
        end
        drive(6'h04, 6'h00, 32'd9, 32'd3, 16'h1234);
        tick();
        n_tests++;
        if (sig_alu_control !== ALU_SUB || src_b !== 32'd3 || src_a !== 32'd9) begin
            n_fail++;
            $display("FAIL beq: code=%0d a=%h b=%h want %0d 9 3", sig_alu_control, src_a, src_b, ALU_SUB);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [5:0] fns[4] = '{6'h20, 6'h22, 6'h24, 6'h25};
        logic [4:0] exp[4] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR};
        logic [4:0] got[$];
        int idx = 0, first = -1, last = -1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (idx < 4) drive(6'h00, fns[idx], 32'(100 + idx), 32'(200 + idx), 16'h0);
            if (in_ready && idx < 4) idx++;
            tick();
        end
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || sig_alu_control !== ALU_ADD || src_a !== 32'd100) begin
            n_fail++;
            $display("FAIL bp_hold: ir=%b ov=%b code=%0d a=%h want 0 1 %0d 00000064",
                     in_ready, out_valid, sig_alu_control, src_a, ALU_ADD);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            if (out_valid) begin
                got.push_back(sig_alu_control);
                if (first < 0) first = c;
                last = c;
            end
            if (idx < 4) drive(6'h00, fns[idx], 32'(100 + idx), 32'(200 + idx), 16'h0);
            else in_valid = 1'b0;
            if (in_ready && idx < 4) idx++;
            tick();
        end
        in_valid = 1'b0;
        n_tests++;
        if (got.size() != 4 || last - first != 3) begin
            n_fail++;
            $display("FAIL bp_stream: got %0d entries over %0d cycles, want 4 over 4",
                     got.size(), last - first + 1);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (got[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL bp_order[%0d]: code=%0d want %0d", i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive(6'h3F, 6'h20, 32'hDEAD, 32'hBEEF, 16'h7777);
        tick();
        n_tests++;
        if (illegal_op !== 1'b1 || sig_alu_control !== ALU_ADD || src_a !== 0 || src_b !== 0) begin
            n_fail++;
            $display("FAIL illegal_opc: ill=%b code=%0d a=%h b=%h want 1 %0d 0 0",
                     illegal_op, sig_alu_control, src_a, src_b, ALU_ADD);
        end
        drive(6'h00, 6'h2A, 32'h1111, 32'h2222, 16'h0);
        tick();
        n_tests++;
        if (illegal_op !== 1'b1 || sig_alu_control !== ALU_ADD || src_a !== 0 || src_b !== 0) begin
            n_fail++;
            $display("FAIL illegal_funct: ill=%b code=%0d a=%h b=%h want 1 %0d 0 0",
                     illegal_op, sig_alu_control, src_a, src_b, ALU_ADD);
        end
        drive(6'h0C, 6'h00, 32'h55, 32'h0, 16'hF0F0);
        tick();
        n_tests++;
        if (illegal_op !== 1'b0 || sig_alu_control !== ALU_AND || src_a !== 32'h55 || src_b !== 32'h0000F0F0) begin
            n_fail++;
            $display("FAIL after_illegal: ill=%b code=%0d a=%h b=%h want 0 %0d 55 f0f0",
                     illegal_op, sig_alu_control, src_a, src_b, ALU_AND);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        bit seen = 0;
        out_ready = 1'b0;
        drive(6'h00, 6'h21, 32'd1, 32'd1, 16'h0); tick();
        drive(6'h00, 6'h23, 32'd2, 32'd2, 16'h0); tick();
        drive(6'h00, 6'h24, 32'd3, 32'd3, 16'h0);
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_setup: ir=%b ov=%b want 0 1", in_ready, out_valid);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush: ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) seen = 1;
            tick();
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL flush_discard: stale entry reappeared=%b want 0", seen);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[10] = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h23, 6'h2B, 6'h0C, 6'h0D, 6'h04, 6'h3A};
        logic [5:0] fns[7]  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A};
        int errs = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            opcode    = ops[$urandom_range(0, 9)];
            funct     = fns[$urandom_range(0, 6)];
            rs_data   = $urandom;
            rt_data   = $urandom;
            imm       = 16'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            tick();
            n_tests++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                n_fail++; errs++;
                if (errs < 10)
                    $display("FAIL rand_hs[%0d]: ov=%b ir=%b want %b %b", c, out_valid, in_ready,
                             q.size() > 0, q.size() < 2);
            end else if (q.size() > 0) begin
                n_tests++;
                if ({src_a, src_b, sig_alu_control, illegal_op} !== q[0]) begin
                    n_fail++; errs++;
                    if (errs < 10)
                        $display("FAIL rand_data[%0d]: a=%h b=%h code=%0d ill=%b want a=%h b=%h code=%0d ill=%b",
                                 c, src_a, src_b, sig_alu_control, illegal_op,
                                 q[0].a, q[0].b, q[0].code, q[0].ill);
                end
            end
        end
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(6'h00, 6'h20, 32'd4, 32'd4, 16'h0); tick();
        drive(6'h00, 6'h22, 32'd6, 32'd6, 16'h0); tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || src_a !== 0 || sig_alu_control !== ALU_ADD) begin
            n_fail++;
            $display("FAIL async_reset: ov=%b ir=%b a=%h code=%0d want 0 1 0 %0d",
                     out_valid, in_ready, src_a, sig_alu_control, ALU_ADD);
        end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: ov=%b want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_illegal();
        test_flush();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage that drives the ALU interface from the producer side.
- Accepts decoded instruction fields plus register-file operands from ID.
- Translates opcode/funct into the 5-bit sig_alu_control code (`ALU_AND, `ALU_OR, `ALU_add, `ALU_sub from ManBearPig.h) and selects/extends src_a and src_b.
- Registers the result into the ID/EX boundary through a valid/ready handshake with a 2-entry skid buffer, so upstream stalls never form a combinational ready path.

Parameters:
WIDTH, 32, operand and immediate-extension width
CODE_W, 5, width of sig_alu_control

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous squash of all held and incoming entries
in_valid  input  1  ID presents a valid instruction
in_ready  output  1  stage can accept an entry this cycle
opcode  input  6  instruction[31:26]
funct  input  6  instruction[5:0]
rs_data  input  WIDTH  register rs value
rt_data  input  WIDTH  register rt value
imm  input  16  instruction[15:0]
out_valid  output  1  entry presented to EX
out_ready  input  1  EX accepts the entry this cycle
src_a  output  WIDTH  ALU operand A
src_b  output  WIDTH  ALU operand B
sig_alu_control  output  CODE_W  ALU operation code
illegal_op  output  1  the presented entry had an unsupported encoding

Behaviour:
- Reset (rst_n low, asynchronous): both buffer entries are invalid.
  - out_valid=0, in_ready=1, src_a=0, src_b=0, sig_alu_control=`ALU_add, illegal_op=0.
- Decode (combinational on inputs, captured at the handshake):
  - opcode 0x00:
    - funct 0x20 or 0x21 -> `ALU_add
    - funct 0x22 or 0x23 -> `ALU_sub
    - funct 0x24 -> `ALU_AND
    - funct 0x25 -> `ALU_OR
    - For all of these: src_a=rs_data, src_b=rt_data.
  - 0x08/0x09 addi/addiu, 0x23 lw, 0x2B sw -> `ALU_add, src_b = sign-extended imm.
  - 0x0C andi -> `ALU_AND, src_b = zero-extended imm.
  - 0x0D ori -> `ALU_OR, src_b = zero-extended imm.
  - 0x04 beq -> `ALU_sub, src_b=rt_data.
  - In all I-type cases src_a=rs_data.
  - Any other opcode, or any other funct under opcode 0x00: illegal_op=1, sig_alu_control=`ALU_add, src_a=0, src_b=0. The stage never emits an undefined code.
- Handshake:
  - An entry transfers in when in_valid & in_ready.
  - An entry transfers out when out_valid & out_ready.
  - out_valid, src_a, src_b, sig_alu_control and illegal_op come from the head register only; they are stable while out_valid=1 and out_ready=0.
- Buffer (head register plus one skid register):
  - Latency: an entry accepted into an empty stage appears at the outputs on the next cycle.
  - Throughput: 1 entry/cycle while out_ready stays high.
  - in_ready is registered and equals !skid_valid.
  - If the head is held (out_ready=0) and a new entry is accepted, the new entry goes to skid and in_ready drops the next cycle.
  - When the head drains, skid moves to head in the same edge and in_ready rises the next cycle.
  - Simultaneous accept and drain with only the head full: the new entry goes straight to head; skid stays empty.
- Ordering: strict FIFO order; no entry is dropped or duplicated.
- flush (synchronous, priority over everything except reset):
  - On the flush edge both entries are invalidated and any in_valid in that cycle is discarded.
  - The next cycle shows out_valid=0 and in_ready=1.
  - If out_valid & out_ready are asserted in the same cycle as flush, that transfer still counts as accepted by EX.
- Reset mid-operation: all state clears immediately; there is no partial output.

Test Plan:
- Reset, then in_valid with opcode=0x00, funct=0x20, rs=5, rt=7, out_ready=1 -> next cycle out_valid=1, sig_alu_control=`ALU_add, src_a=5, src_b=7, illegal_op=0.
- Immediate forms:
  - addi with imm=0xFFFF, rs=10 -> src_b=0xFFFFFFFF, `ALU_add.
  - ori with imm=0x8001 -> src_b=0x00008001, `ALU_OR.
  - beq with rt=3 -> `ALU_sub, src_b=3.
- Backpressure: stream 4 entries (add, sub, and, or) with out_ready=0 for 3 cycles.
  - in_ready falls after the second accept.
  - Outputs hold the first entry.
  - After release, all 4 emerge in order with no gaps once the stream restarts.
- Illegal encodings: opcode=0x3F, then opcode=0x00 funct=0x2A -> illegal_op=1, sig_alu_control=`ALU_add, src_a=src_b=0; the following legal entry decodes normally.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the discarded entries never appear.
- Assert rst_n low asynchronously mid-stream (between edges) -> out_valid=0 and in_ready=1 immediately, before the next clock edge.
